// File: rtl/dcmac_rx_merge.sv
// dcmac_rx_merge
//   Merges the four per-segment AXI streams from the DCMAC rx segment buffers
//   into one 128-bit packet stream. Segments are drained strictly round-robin
//   (seg0 -> seg1 -> seg2 -> seg3 -> seg0), at most one per clock. SOP/EOP
//   framing and a maximum packet length are enforced here.
//
// Ports
//   clk, resetn            single clock, asynchronous active-low reset
//   segN_tdata/tid/tuser   segment data, mty (empty high bytes), {ena, sop, err}
//   segN_tlast/tvalid      segment eop / valid
//   segN_tready            segment accept (only seg[ptr] can be ready)
//   m_axis_*               packet stream; tuser is the packet error, valid on tlast
//   proto_err              one-cycle pulse per framing violation
//   pkt_count/err_count/drop_count  saturating statistics
//
// Optional build macro
//   RX_STATS_EN  builds the statistics counters; otherwise they read as 0.
module dcmac_rx_merge #(
  parameter int MAX_PKT_BYTES = 9600,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [127:0]     seg0_tdata,
  input  logic [3:0]       seg0_tid,
  input  logic [2:0]       seg0_tuser,
  input  logic             seg0_tlast,
  input  logic             seg0_tvalid,
  output logic             seg0_tready,
  input  logic [127:0]     seg1_tdata,
  input  logic [3:0]       seg1_tid,
  input  logic [2:0]       seg1_tuser,
  input  logic             seg1_tlast,
  input  logic             seg1_tvalid,
  output logic             seg1_tready,
  input  logic [127:0]     seg2_tdata,
  input  logic [3:0]       seg2_tid,
  input  logic [2:0]       seg2_tuser,
  input  logic             seg2_tlast,
  input  logic             seg2_tvalid,
  output logic             seg2_tready,
  input  logic [127:0]     seg3_tdata,
  input  logic [3:0]       seg3_tid,
  input  logic [2:0]       seg3_tuser,
  input  logic             seg3_tlast,
  input  logic             seg3_tvalid,
  output logic             seg3_tready,
  output logic [127:0]     m_axis_tdata,
  output logic [15:0]      m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             proto_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, IN_PKT = 2'd1, DISCARD = 2'd2} state_t;

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [15:0]  byte_cnt_q, byte_cnt_d;
  logic         err_acc_q, err_acc_d;
  logic [127:0] tdata_q, tdata_d;
  logic [15:0]  tkeep_q, tkeep_d;
  logic         tlast_q, tlast_d, tuser_q, tuser_d, tvalid_q, tvalid_d;
  logic         proto_err_q, proto_err_d;
  logic         drop_take;

  logic [127:0] s_data [4];
  logic [3:0]   s_mty  [4];
  logic [3:0]   s_sop, s_err, s_eop, s_valid;

  assign s_data  = '{seg0_tdata, seg1_tdata, seg2_tdata, seg3_tdata};
  assign s_mty   = '{seg0_tid, seg1_tid, seg2_tid, seg3_tid};
  assign s_sop   = {seg3_tuser[1], seg2_tuser[1], seg1_tuser[1], seg0_tuser[1]};
  assign s_err   = {seg3_tuser[0], seg2_tuser[0], seg1_tuser[0], seg0_tuser[0]};
  assign s_eop   = {seg3_tlast, seg2_tlast, seg1_tlast, seg0_tlast};
  assign s_valid = {seg3_tvalid, seg2_tvalid, seg1_tvalid, seg0_tvalid};

  // The ena bit carries no information this block needs.
  logic unused_ena;
  assign unused_ena = ^{seg0_tuser[2], seg1_tuser[2], seg2_tuser[2], seg3_tuser[2]};

  logic [127:0] cur_data;
  logic [3:0]   cur_mty;
  logic         cur_sop, cur_err, cur_eop, cur_valid;
  logic [4:0]   cur_len;
  logic [15:0]  cur_keep;
  logic [16:0]  cnt_sum;
  logic         over_len, load_ok, drop_cur, cur_ready, take;

  assign cur_data  = s_data[ptr_q];
  assign cur_mty   = s_mty[ptr_q];
  assign cur_sop   = s_sop[ptr_q];
  assign cur_err   = s_err[ptr_q];
  assign cur_eop   = s_eop[ptr_q];
  assign cur_valid = s_valid[ptr_q];
  assign cur_len   = 5'd16 - {1'b0, cur_mty};
  assign cur_keep  = 16'hFFFF >> cur_mty;
  assign cnt_sum   = {1'b0, byte_cnt_q} + {12'd0, cur_len};
  assign over_len  = cnt_sum > 17'(MAX_PKT_BYTES);

  // Segments that will be dropped never need the output register, so they
  // are accepted even while the output is stalled.
  assign load_ok   = !tvalid_q || m_axis_tready;
  assign drop_cur  = (state_q == DISCARD) || (state_q == IDLE && !cur_sop);
  assign cur_ready = resetn && (load_ok || drop_cur);
  assign take      = cur_valid && cur_ready;

  assign seg0_tready = (ptr_q == 2'd0) && cur_ready;
  assign seg1_tready = (ptr_q == 2'd1) && cur_ready;
  assign seg2_tready = (ptr_q == 2'd2) && cur_ready;
  assign seg3_tready = (ptr_q == 2'd3) && cur_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    byte_cnt_d  = byte_cnt_q;
    err_acc_d   = err_acc_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tvalid_d    = tvalid_q && !m_axis_tready;
    proto_err_d = 1'b0;
    drop_take   = 1'b0;
    if (take) begin
      ptr_d = ptr_q + 2'd1;
      case (state_q)
        IDLE: begin
          if (cur_sop) begin
            tvalid_d   = 1'b1;
            tdata_d    = cur_data;
            tkeep_d    = cur_keep;
            tlast_d    = cur_eop;
            tuser_d    = cur_eop && cur_err;
            byte_cnt_d = {11'd0, cur_len};
            err_acc_d  = cur_err;
            state_d    = cur_eop ? IDLE : IN_PKT;
          end else begin
            drop_take   = 1'b1;
            proto_err_d = 1'b1;
          end
        end
        IN_PKT: begin
          tvalid_d = 1'b1;
          if (cur_sop) begin
            // Missing EOP: close the open packet with an empty error beat.
            tdata_d     = '0;
            tkeep_d     = '0;
            tlast_d     = 1'b1;
            tuser_d     = 1'b1;
            drop_take   = 1'b1;
            proto_err_d = 1'b1;
            state_d     = cur_eop ? IDLE : DISCARD;
          end else if (over_len) begin
            tdata_d     = cur_data;
            tkeep_d     = cur_keep;
            tlast_d     = 1'b1;
            tuser_d     = 1'b1;
            proto_err_d = 1'b1;
            state_d     = cur_eop ? IDLE : DISCARD;
          end else begin
            tdata_d    = cur_data;
            tkeep_d    = cur_keep;
            tlast_d    = cur_eop;
            tuser_d    = cur_eop && (err_acc_q || cur_err);
            byte_cnt_d = sat16(cnt_sum);
            err_acc_d  = err_acc_q || cur_err;
            if (cur_eop) state_d = IDLE;
          end
        end
        default: begin
          drop_take = 1'b1;
          if (cur_eop) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      byte_cnt_q  <= '0;
      err_acc_q   <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      err_acc_q   <= err_acc_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tvalid_q    <= tvalid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign proto_err     = proto_err_q;

`ifdef RX_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  logic [CNT_W-1:0] pkt_count_q, pkt_count_d, err_count_q, err_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             pop_last;

  assign pop_last = tvalid_q && m_axis_tready && tlast_q;

  always_comb begin
    pkt_count_d  = sat_inc(pkt_count_q, pop_last);
    err_count_d  = sat_inc(err_count_q, pop_last && tuser_q);
    drop_count_d = sat_inc(drop_count_q, drop_take);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign err_count  = err_count_q;
  assign drop_count = drop_count_q;
`else
  logic unused_drop_take;
  assign unused_drop_take = drop_take;
  assign pkt_count  = '0;
  assign err_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_dcmac_rx_merge.sv
module tb_dcmac_rx_merge;
  localparam int MAXB = 9600;
`ifdef RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] seg_tdata [4];
  logic [3:0]   seg_tid   [4];
  logic [2:0]   seg_tuser [4];
  logic [3:0]   seg_tlast, seg_tvalid;
  logic         rdy0, rdy1, rdy2, rdy3;
  wire  [3:0]   seg_tready = {rdy3, rdy2, rdy1, rdy0};
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready, proto_err;
  logic [31:0]  pkt_count, err_count, drop_count;

  dcmac_rx_merge u_dut (
    .clk(clk), .resetn(resetn),
    .seg0_tdata(seg_tdata[0]), .seg0_tid(seg_tid[0]), .seg0_tuser(seg_tuser[0]),
    .seg0_tlast(seg_tlast[0]), .seg0_tvalid(seg_tvalid[0]), .seg0_tready(rdy0),
    .seg1_tdata(seg_tdata[1]), .seg1_tid(seg_tid[1]), .seg1_tuser(seg_tuser[1]),
    .seg1_tlast(seg_tlast[1]), .seg1_tvalid(seg_tvalid[1]), .seg1_tready(rdy1),
    .seg2_tdata(seg_tdata[2]), .seg2_tid(seg_tid[2]), .seg2_tuser(seg_tuser[2]),
    .seg2_tlast(seg_tlast[2]), .seg2_tvalid(seg_tvalid[2]), .seg2_tready(rdy2),
    .seg3_tdata(seg_tdata[3]), .seg3_tid(seg_tid[3]), .seg3_tuser(seg_tuser[3]),
    .seg3_tlast(seg_tlast[3]), .seg3_tvalid(seg_tvalid[3]), .seg3_tready(rdy3),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .proto_err(proto_err), .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count)
  );

  typedef struct { logic [127:0] data; logic [3:0] mty; logic sop, eop, err; } seg_t;
  typedef struct { logic [127:0] data; logic [15:0] keep; logic last, user; } beat_t;

  seg_t  sq [4][$];
  beat_t eq[$];
  beat_t got[$];
  int    got_cyc[$];

  int checks = 0, errors = 0;
  int cyc_g = 0;
  int gen_ptr = 0, mptr = 0;
  bit in_pkt = 0, discarding = 0, macc = 0;
  int mcnt = 0;
  int exp_drops = 0, exp_proto = 0, exp_pkts = 0, exp_errs = 0, obs_proto = 0;
  int gap = 0, rmode = 0;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  // ---------------- reference model (packet-level rules) ----------------
  function automatic bit model_drop(input seg_t s);
    return discarding || (!in_pkt && !s.sop);
  endfunction

  task automatic model_take(input seg_t s);
    beat_t b;
    int len;
    len = 16 - int'(s.mty);
    b.data = s.data; b.keep = '0; b.last = s.eop; b.user = 1'b0;
    for (int i = 0; i < len; i++) b.keep[i] = 1'b1;
    if (discarding) begin
      exp_drops++;
      if (s.eop) discarding = 0;
    end else if (!in_pkt) begin
      if (s.sop) begin
        mcnt = len; macc = s.err; b.user = s.err;
        eq.push_back(b);
        in_pkt = !s.eop;
      end else begin
        exp_drops++; exp_proto++;
      end
    end else if (s.sop) begin
      b.data = '0; b.keep = '0; b.last = 1; b.user = 1;
      eq.push_back(b);
      exp_drops++; exp_proto++;
      in_pkt = 0; discarding = !s.eop;
    end else if (mcnt + len > MAXB) begin
      b.last = 1; b.user = 1;
      eq.push_back(b);
      exp_proto++;
      in_pkt = 0; discarding = !s.eop;
    end else begin
      mcnt += len; macc = macc | s.err; b.user = macc;
      eq.push_back(b);
      if (s.eop) in_pkt = 0;
    end
    mptr = (mptr + 1) % 4;
  endtask

  task automatic model_clear();
    for (int n = 0; n < 4; n++) sq[n].delete();
    eq.delete(); got.delete(); got_cyc.delete();
    gen_ptr = 0; mptr = 0; in_pkt = 0; discarding = 0; macc = 0; mcnt = 0;
    exp_drops = 0; exp_proto = 0; exp_pkts = 0; exp_errs = 0; obs_proto = 0;
  endtask

  // ---------------- stimulus generation ----------------
  task automatic push_seg(input bit sop, input bit eop, input bit err, input int mty);
    seg_t s;
    s.data = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 16 - mty; b < 16; b++) s.data[b*8 +: 8] = 8'h00;
    s.mty = 4'(mty); s.sop = sop; s.eop = eop; s.err = err;
    sq[gen_ptr].push_back(s);
    gen_ptr = (gen_ptr + 1) % 4;
  endtask

  task automatic push_pkt(input int nbytes, input bit err, input bit noeop);
    int nseg, mty, epos;
    nseg = (nbytes + 15) / 16;
    mty  = nseg * 16 - nbytes;
    epos = err ? int'($urandom_range(0, nseg - 1)) : -1;
    for (int i = 0; i < nseg; i++)
      push_seg(i == 0, (i == nseg - 1) && !noeop, i == epos, (i == nseg - 1) ? mty : 0);
  endtask

  task automatic drive_idle(input int n);
    seg_tdata[n] = {$urandom, $urandom, $urandom, $urandom};
    seg_tid[n] = 4'($urandom); seg_tuser[n] = 3'($urandom); seg_tlast[n] = 1'($urandom);
    seg_tvalid[n] = 1'b0;
  endtask

  // Drives the queued segments, feeds the model on every take and scores
  // every accepted output beat until the traffic drains.
  task automatic run_traffic(input int budget, input int stop_beats);
    int cyc, idle, beats, tp;
    bit held_v, load_ok;
    beat_t held, ob, ex;
    bit [3:0] took;
    cyc = 0; idle = 0; beats = 0; held_v = 0;
    while (1) begin
      @(negedge clk);
      load_ok = !m_axis_tvalid || m_axis_tready;
      took = seg_tvalid & seg_tready;
      tp = mptr;
      checks++;
      if ((seg_tready & ~(4'b0001 << tp)) != 4'b0000) begin
        errors++; $display("FAIL tready_sel got %b ptr %0d", seg_tready, tp);
      end
      if (seg_tvalid[tp] && sq[tp].size() > 0) begin
        checks++;
        if (seg_tready[tp] !== (load_ok || model_drop(sq[tp][0]))) begin
          errors++; $display("FAIL tready_ptr seg%0d got %b exp %b", tp, seg_tready[tp], load_ok || model_drop(sq[tp][0]));
        end
      end
      if (took[tp] && sq[tp].size() > 0) model_take(sq[tp][0]);
      ob.data = m_axis_tdata; ob.keep = m_axis_tkeep; ob.last = m_axis_tlast; ob.user = m_axis_tuser;
      if (held_v) begin
        checks++;
        if (!m_axis_tvalid || ob.data !== held.data || ob.keep !== held.keep || ob.last !== held.last || ob.user !== held.user) begin
          errors++; $display("FAIL hold_stable valid %b data %h exp %h", m_axis_tvalid, ob.data, held.data);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (eq.size() == 0) begin
          errors++; $display("FAIL stray_beat data %h keep %h last %b", ob.data, ob.keep, ob.last);
        end else begin
          ex = eq.pop_front();
          if (ob.data !== ex.data || ob.keep !== ex.keep || ob.last !== ex.last || (ex.last && ob.user !== ex.user)) begin
            errors++;
            $display("FAIL beat got %h/%h/%b/%b exp %h/%h/%b/%b", ob.data, ob.keep, ob.last, ob.user, ex.data, ex.keep, ex.last, ex.user);
          end
          if (ex.last) exp_pkts++;
          if (ex.last && ex.user) exp_errs++;
        end
        got.push_back(ob); got_cyc.push_back(cyc_g); beats++;
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held = ob;
      if (proto_err) obs_proto++;
      @(posedge clk); #1;
      for (int n = 0; n < 4; n++) if (took[n] && sq[n].size() > 0) void'(sq[n].pop_front());
      for (int n = 0; n < 4; n++) begin
        if (sq[n].size() > 0 && ((seg_tvalid[n] && !took[n]) || $urandom_range(0, 99) >= gap)) begin
          seg_tdata[n] = sq[n][0].data; seg_tid[n] = sq[n][0].mty;
          seg_tuser[n] = {1'b1, sq[n][0].sop, sq[n][0].err}; seg_tlast[n] = sq[n][0].eop;
          seg_tvalid[n] = 1'b1;
        end else drive_idle(n);
      end
      case (rmode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = !m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 2) != 0);
      endcase
      cyc++;
      if (stop_beats > 0 && beats >= stop_beats) break;
      if (sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size() == 0 && eq.size() == 0 && !m_axis_tvalid)
        idle++;
      else idle = 0;
      if (idle >= 4) break;
      if (cyc >= budget) begin
        errors++; $display("FAIL timeout after %0d cycles, %0d beats pending", cyc, eq.size());
        break;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int n = 0; n < 4; n++) begin
      seg_tdata[n] = {$urandom, $urandom, $urandom, $urandom};
      seg_tid[n] = 4'd0; seg_tuser[n] = 3'b110; seg_tlast[n] = 1'b0; seg_tvalid[n] = 1'b1;
    end
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    for (int n = 0; n < 4; n++) drive_idle(n);
    model_clear();
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
      errors++; $display("FAIL reset_out valid %b data %h keep %h last %b user %b", m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
    checks++;
    if (seg_tready !== 4'b0000 || proto_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctl tready %b proto_err %b exp 0000/0", seg_tready, proto_err);
    end
    checks++;
    if (pkt_count !== 32'd0 || err_count !== 32'd0 || drop_count !== 32'd0) begin
      errors++; $display("FAIL reset_cnt %0d %0d %0d exp 0 0 0", pkt_count, err_count, drop_count);
    end
    release_reset();
  endtask

  task automatic test_64b();
    gap = 0; rmode = 0; got.delete(); got_cyc.delete();
    push_pkt(64, 0, 0);
    run_traffic(200, 0);
    checks++;
    if (got.size() != 4 || got_cyc[3] - got_cyc[0] != 3) begin
      errors++; $display("FAIL b64_timing beats %0d span %0d exp 4/3", got.size(), got.size() == 4 ? got_cyc[3] - got_cyc[0] : -1);
    end else begin
      checks++;
      if (got[3].keep !== 16'hFFFF || !got[3].last || got[3].user || got[2].last) begin
        errors++; $display("FAIL b64_last keep %h last %b user %b exp FFFF/1/0", got[3].keep, got[3].last, got[3].user);
      end
    end
    checks++;
    if (pkt_count !== 32'(STATS ? 1 : 0)) begin
      errors++; $display("FAIL b64_pkt_count got %0d exp %0d", pkt_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_65b();
    gap = 0; rmode = 0; got.delete();
    push_pkt(65, 0, 0);
    run_traffic(200, 0);
    checks++;
    if (got.size() != 5 || got[4].keep !== 16'h0001 || !got[4].last) begin
      errors++; $display("FAIL b65_last beats %0d keep %h exp 5/0001", got.size(), got.size() == 5 ? got[4].keep : 16'h0);
    end
    checks++;
    if (seg_tready !== 4'b0010) begin
      errors++; $display("FAIL b65_ptr tready %b exp 0010", seg_tready);
    end
  endtask

  task automatic test_backpressure();
    gap = 0; rmode = 1; got.delete();
    push_pkt(157, 1, 0);
    run_traffic(400, 0);
    checks++;
    if (got.size() != 10 || !got[9].last || got[9].user !== 1'b1 || got[9].keep !== 16'h1FFF) begin
      errors++; $display("FAIL bp_beats got %0d exp 10", got.size());
    end
    checks++;
    if (pkt_count !== 32'(STATS ? exp_pkts : 0) || err_count !== 32'(STATS ? exp_errs : 0)) begin
      errors++; $display("FAIL bp_counts got %0d/%0d exp %0d/%0d", pkt_count, err_count, STATS ? exp_pkts : 0, STATS ? exp_errs : 0);
    end
  endtask

  task automatic test_missing_eop();
    int d0, p0;
    gap = 0; rmode = 0; got.delete();
    d0 = 32'(drop_count); p0 = obs_proto;
    push_seg(1, 0, 0, 0);
    push_seg(1, 0, 0, 0);
    push_seg(0, 0, 0, 0);
    push_seg(0, 1, 0, 4);
    run_traffic(200, 0);
    checks++;
    if (got.size() != 2 || got[1].keep !== 16'h0 || got[1].data !== '0 || !got[1].last || !got[1].user) begin
      errors++; $display("FAIL meop_term beats %0d exp 2 with empty error terminator", got.size());
    end
    checks++;
    if (obs_proto - p0 != 1 || 32'(drop_count) - d0 != (STATS ? 3 : 0)) begin
      errors++; $display("FAIL meop_counts proto %0d drops %0d exp 1/%0d", obs_proto - p0, 32'(drop_count) - d0, STATS ? 3 : 0);
    end
  endtask

  task automatic test_overflow();
    int e0;
    gap = 0; rmode = 0; got.delete();
    e0 = 32'(err_count);
    for (int i = 0; i < 603; i++) push_seg(i == 0, i == 602, 0, 0);
    run_traffic(3000, 0);
    checks++;
    if (got.size() != 601 || !got[600].last || !got[600].user || got[599].last) begin
      errors++; $display("FAIL ovf_trunc beats %0d exp 601 with last+user on final", got.size());
    end
    checks++;
    if (32'(err_count) - e0 != (STATS ? 1 : 0) || drop_count !== 32'(STATS ? exp_drops : 0)) begin
      errors++; $display("FAIL ovf_counts err +%0d drops %0d exp +%0d/%0d", 32'(err_count) - e0, drop_count, STATS ? 1 : 0, STATS ? exp_drops : 0);
    end
  endtask

  task automatic test_reset_mid();
    gap = 0; rmode = 0; got.delete();
    push_pkt(96, 0, 0);
    run_traffic(100, 2);
    do_reset();
    release_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid got %b exp 0", m_axis_tvalid);
    end
    push_pkt(30, 0, 0);
    run_traffic(200, 0);
    checks++;
    if (got.size() != 2 || !got[1].last || got[0].last || got[1].keep !== 16'h3FFF) begin
      errors++; $display("FAIL rst_mid_clean beats %0d exp 2", got.size());
    end
    checks++;
    if (pkt_count !== 32'(STATS ? 1 : 0) || drop_count !== 32'd0) begin
      errors++; $display("FAIL rst_mid_counts pkt %0d drop %0d exp %0d/0", pkt_count, drop_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_random();
    int kind;
    gap = 30; rmode = 2;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) push_seg(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
      else push_pkt(int'($urandom_range(1, 120)), $urandom_range(0, 3) == 0, kind == 1);
    end
    push_pkt(20, 0, 0);
    run_traffic(20000, 0);
    checks++;
    if (obs_proto != exp_proto) begin
      errors++; $display("FAIL rnd_proto got %0d exp %0d", obs_proto, exp_proto);
    end
    checks++;
    if (pkt_count !== 32'(STATS ? exp_pkts : 0) || err_count !== 32'(STATS ? exp_errs : 0) || drop_count !== 32'(STATS ? exp_drops : 0)) begin
      errors++; $display("FAIL rnd_counts got %0d/%0d/%0d exp %0d/%0d/%0d", pkt_count, err_count, drop_count,
                         STATS ? exp_pkts : 0, STATS ? exp_errs : 0, STATS ? exp_drops : 0);
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    for (int n = 0; n < 4; n++) drive_idle(n);
    test_reset();
    test_64b();
    test_65b();
    test_backpressure();
    test_missing_eop();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
